// File: rtl/mu_pkg.sv
// Shared constants for the MU request path.
// Instantiators pass REQ_WIDTH as the request FIFO data width.
package mu_pkg;
    localparam int REQ_WIDTH = 32;
endpackage : mu_pkg

// File: rtl/mu_fifo_mem.sv
// Register-array storage for the request FIFO.
// One synchronous write port and one asynchronous read port.
module mu_fifo_mem #(
    parameter int Width = 32,
    parameter int Depth = 4,
    localparam int AW   = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem [Depth];

    // NOTE: storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule : mu_fifo_mem

// File: rtl/mu_req_fifo.sv
// Request FIFO with ready/valid handshakes, synchronous flush and async reset.
// Ready and valid come straight from registered occupancy; no bypass path.
module mu_req_fifo
    import mu_pkg::*;
#(
    parameter int Width = REQ_WIDTH,
    parameter int Depth = 4,
    localparam int AW   = $clog2(Depth),
    localparam int CW   = $clog2(Depth) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [Width-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [Width-1:0] out_data_o,
    input  logic             out_ready_i,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_check
        $error("mu_req_fifo: Depth must be a power of two and at least 2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push, pop;

    assign full_o      = (count_q == CW'(Depth));
    assign empty_o     = (count_q == '0);
    assign in_ready_o  = !full_o;
    assign out_valid_o = !empty_o;
    assign count_o     = count_q;

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    mu_fifo_mem #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push && !flush_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (out_data_o)
    );

endmodule : mu_req_fifo
